// File: rtl/ms_pkg.sv
// Shared constants and word type for the master-slave flip-flop cell.
`timescale 1ns/1ps
package ms_pkg;

  localparam int unsigned WORD_W = 1;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t Q_RESET  = '0;
  localparam word_t Q_PRESET = '1;

endpackage

// File: rtl/ms_dff_d_latch.sv
// Level-sensitive D latch, transparent while en is high.
`timescale 1ns/1ps
module d_latch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_latch begin
    if (en) q <= d;
  end

endmodule

// File: rtl/ms_dff.sv
// Positive-edge master-slave flip-flop built from two latches, with
// synchronous active-low clear (dominant) and preset in front of the master.
`timescale 1ns/1ps
module ms_dff
  import ms_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             prs_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b
);

  logic             clk_n;
  logic [WIDTH-1:0] next_c;
  logic [WIDTH-1:0] master_q;

  assign clk_n = ~clk;

  // Clear wins over preset; both only reach q through the latch pair.
  always_comb begin
    next_c = d;
    if (!clr_b)      next_c = {WIDTH{Q_RESET[0]}};
    else if (!prs_b) next_c = {WIDTH{Q_PRESET[0]}};
  end

  d_latch #(.WIDTH(WIDTH)) u_master (
    .en (clk_n),
    .d  (next_c),
    .q  (master_q)
  );

  d_latch #(.WIDTH(WIDTH)) u_slave (
    .en (clk),
    .d  (master_q),
    .q  (q)
  );

  assign q_b = ~q;

endmodule

// File: tb/tb_ms_dff.sv
// Bench for ms_dff: edge-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_ms_dff;

  localparam int unsigned HALF = 15260;

  logic       clk = 1'b0;
  logic       clr1, prs1;
  logic [0:0] d1, q1, qb1;
  logic       clr4, prs4;
  logic [3:0] d4, q4, qb4;

  int checks = 0;
  int errors = 0;

  logic [3:0] m1, m4;
  bit         mvalid = 1'b0;

  ms_dff #(.WIDTH(1)) dut1 (
    .clk(clk), .clr_b(clr1), .prs_b(prs1), .d(d1), .q(q1), .q_b(qb1)
  );

  ms_dff #(.WIDTH(4)) dut4 (
    .clk(clk), .clr_b(clr4), .prs_b(prs4), .d(d4), .q(q4), .q_b(qb4)
  );

  always #HALF clk = ~clk;

  // Value the flip-flop must hold after an edge, from the priority rules.
  function automatic logic [3:0] expect_next(logic c, logic p, logic [3:0] dv, int w);
    logic [3:0] mask;
    mask = 4'((1 << w) - 1);
    if (!c)      return 4'b0000;
    else if (!p) return mask;
    else         return dv & mask;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    m1 = expect_next(clr1, prs1, {3'b000, d1}, 1);
    m4 = expect_next(clr4, prs4, d4, 4);
    mvalid = 1'b1;
  end

  // Continuous comparison just after every edge and mid-phase.
  always begin
    @(clk);
    #1;
    if (mvalid) begin
      chk("model_q1",  {3'b000, q1},  m1);
      chk("model_qb1", {3'b000, qb1}, ~m1 & 4'b0001);
      chk("model_q4",  q4,  m4);
      chk("model_qb4", qb4, ~m4);
    end
    #6000;
    if (mvalid) begin
      chk("mid_q1", {3'b000, q1}, m1);
      chk("mid_q4", q4, m4);
    end
  end

  initial begin
    clr1 = 1'b0; prs1 = 1'b1; d1 = 1'b1;
    clr4 = 1'b0; prs4 = 1'b1; d4 = 4'b1111;

    // Reset across the first rising edge; d is ignored.
    @(posedge clk); #100;
    chk("reset_q1",  {3'b000, q1},  4'b0000);
    chk("reset_qb1", {3'b000, qb1}, 4'b0001);
    chk("reset_q4",  q4,  4'b0000);
    chk("reset_qb4", qb4, 4'b1111);

    // Clear released while clk low: q holds 0 until the next rising edge.
    @(negedge clk); #3000;
    clr1 = 1'b1;
    #5000;
    chk("clr_release_hold", {3'b000, q1}, 4'b0000);
    @(posedge clk); #100;
    chk("clr_release_q",  {3'b000, q1},  4'b0001);
    chk("clr_release_qb", {3'b000, qb1}, 4'b0000);
    @(negedge clk); #100;
    chk("falling_edge_q", {3'b000, q1}, 4'b0001);

    // d toggles every 14 us, offset so no toggle lands on a clock edge.
    @(posedge clk); #3000;
    repeat (8) begin
      #14000 d1 = ~d1;
    end

    // Preset forces ones and ignores d.
    @(negedge clk); #3000;
    d1 = 1'b0; prs1 = 1'b0;
    @(posedge clk); #100;
    chk("preset_q", {3'b000, q1}, 4'b0001);
    #5000 d1 = 1'b1;
    @(negedge clk); #3000 d1 = 1'b0;
    @(posedge clk); #100;
    chk("preset_hold_q", {3'b000, q1}, 4'b0001);

    // Clear and preset together: clear wins; then preset alone.
    @(negedge clk); #3000;
    clr1 = 1'b0; prs1 = 1'b0; d1 = 1'b1;
    @(posedge clk); #100;
    chk("clr_prs_q", {3'b000, q1}, 4'b0000);
    @(negedge clk); #3000;
    clr1 = 1'b1;
    #5000;
    chk("clr_prs_release_hold", {3'b000, q1}, 4'b0000);
    @(posedge clk); #100;
    chk("prs_after_clr_q", {3'b000, q1}, 4'b0001);

    // Four-bit word: independent bits, then clear.
    @(negedge clk); #3000;
    clr4 = 1'b1; prs4 = 1'b1; d4 = 4'b1010;
    @(posedge clk); #100;
    chk("w4_q",  q4,  4'b1010);
    chk("w4_qb", qb4, 4'b0101);
    @(negedge clk); #3000;
    clr4 = 1'b0;
    @(posedge clk); #100;
    chk("w4_clr_q",  q4,  4'b0000);
    chk("w4_clr_qb", qb4, 4'b1111);

    // Directed mixed vectors, checked by the model.
    prs1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #3000;
      d4   = 4'(i * 5 + 3);
      clr4 = (i != 2);
      prs4 = (i != 5);
      d1   = 1'(i);
      clr1 = (i != 6);
      prs1 = (i != 3);
    end
    @(posedge clk); #100;
    chk("final_q4", q4, 4'b0110);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_dff.md
Name: ms_dff

Overview:
- Positive-edge master-slave D flip-flop with synchronous active-low clear and synchronous active-low preset.
- Built from two level-sensitive D latches.
- Leaf storage cell for timer/counter datapaths.
- Provides true and complementary outputs.

Parameters:
- WIDTH, 1, number of independent bit cells. All share clk, clr_b and prs_b.

Ports:
- clk  input  1  clock; data captured on rising edge
- clr_b  input  1  synchronous reset, active-low; forces q to 0 at rising edge
- prs_b  input  1  synchronous preset, active-low; forces q to all-ones at rising edge
- d  input  WIDTH  data input
- q  output  WIDTH  stored value
- q_b  output  WIDTH  complement of q

Behaviour:
- Interface: one clock, clk; reset is clr_b, synchronous and active-low. No asynchronous paths.
- Next-state selection, evaluated combinationally in front of the master latch:
  - clr_b=0 → 0, regardless of prs_b and d. Clear has priority.
  - else prs_b=0 → all-ones.
  - else → d.
- Master latch:
  - Transparent while clk=0.
  - Holds while clk=1.
- Slave latch:
  - Transparent while clk=1.
  - Holds while clk=0.
  - Slave output is q.
- Net effect:
  - q takes the selected next-state value present just before each clk rising edge.
  - q is stable for the full clock period.
  - Latency is one rising edge.
- q_b = ~q at all times; combinational inverter on the slave output, never stored separately.
- Stimulus timing:
  - Changes on d, clr_b or prs_b while clk=1 have no effect until the next rising edge.
  - Changes while clk=0 are overwritten by later changes before the edge.
- Reset value:
  - After any rising edge with clr_b=0: q=0, q_b=all-ones.
  - Before the first rising edge, q is undefined. The integrator must hold clr_b low across at least one rising edge.
- clr_b deassert mid-period: takes effect only at the next rising edge. q stays 0 until then.
- Simultaneous clr_b=0 and prs_b=0: q=0.
- Hold, clr_b=1 and prs_b=1: q=d per edge; no enable input.
- Falling edge of clk: q never changes.
- Each bit index i uses only d[i]; no cross-bit logic.

Decomposition:
- Shared package ms_pkg:
  - Localparam Q_RESET = 0.
  - Localparam Q_PRESET = all-ones.
  - Typedef for the WIDTH-bit data word.
- One sub-module, d_latch:
  - Ports: en, d, q. Parameterised by WIDTH.
  - Transparent when en=1.
  - Instantiated twice:
    - Master, with en=~clk.
    - Slave, with en=clk.
- Top holds only the clr/prs select mux and the q_b inverter.

Test Plan:
- Clock period 30.52 us. Start clr_b=0, prs_b=1, d=1 → after first rising edge at 15.26 us: q=0, q_b=1. d=1 is ignored.
- clr_b→1 while clk low, d=1, prs_b=1 → q stays 0 until the next rising edge, then q=1, q_b=0. q unchanged on the following falling edge.
- clr_b=1, prs_b=1; d toggles 1/0/1 every 14 us → q equals d sampled at each rising edge only. Toggles while clk=1 produce no q change.
- clr_b=1, prs_b=0, d=0 → q=1 at the next rising edge. It stays 1 regardless of d toggling while prs_b=0.
- clr_b=0, prs_b=0, d=1 → q=0 at the rising edge (clear wins). Release clr_b with prs_b still 0 → q=1 at the next edge.
- WIDTH=4, clr_b=1, prs_b=1, d=4'b1010 → q=4'b1010, q_b=4'b0101 after one edge. Then clr_b=0 → q=4'b0000.
